// File: rtl/usb_transmitter_if.sv
// Handshake and line signals between the packet source and the USB transmitter.
interface usb_transmitter_if;
  logic       tx_start;
  logic [7:0] t_data;
  logic       t_empty;
  logic       t_read;
  logic       d_plus;
  logic       d_minus;
  logic       transmitting;
  logic       tx_done;

  modport master (
    output tx_start, t_data, t_empty,
    input  t_read, d_plus, d_minus, transmitting, tx_done
  );

  modport slave (
    input  tx_start, t_data, t_empty,
    output t_read, d_plus, d_minus, transmitting, tx_done
  );
endinterface

// File: rtl/usb_transmitter.sv
// USB low-level packet transmitter: SYNC, LSB-first data from a FWFT FIFO,
// NRZI encoding with bit stuffing, then SE0/J end-of-packet. One bit = 8 clk.
//
// state   | meaning
// IDLE    | lines at J, waiting for tx_start with a non-empty FIFO
// SYNC    | sending the 8-bit SYNC pattern
// DATA    | sending payload bits from the shift register
// STUFF   | one inserted 0 after six consecutive 1s
// EOP_SE0 | both lines low for two bit times
// EOP_J   | J for one bit time, then back to IDLE with tx_done
module usb_transmitter (
  input  logic              clk,
  input  logic              n_rst,
  usb_transmitter_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_t;

  state_t     state_q, state_d;
  logic [2:0] timer_q, timer_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] ones_q, ones_d;
  logic [2:0] ones_nx;
  logic [7:0] shift_q, shift_d;
  logic       dp_q, dp_d;
  logic       dm_q, dm_d;
  logic       tx_done_q, tx_done_d;
  logic       t_read_c;
  logic       adv;
  logic       snd;
  logic       nb;

  // State, timer, shifter and registered line drivers.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q   <= IDLE;
      timer_q   <= 3'd0;
      bit_cnt_q <= 3'd0;
      ones_q    <= 3'd0;
      shift_q   <= 8'h00;
      dp_q      <= 1'b1;
      dm_q      <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      ones_q    <= ones_d;
      shift_q   <= shift_d;
      dp_q      <= dp_d;
      dm_q      <= dm_d;
      tx_done_q <= tx_done_d;
    end
  end

  // Next-state logic: decisions are taken in the last cycle of each bit and the
  // line value for the following bit is loaded on that same edge.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 3'd1;
    bit_cnt_d = bit_cnt_q;
    ones_d    = ones_q;
    shift_d   = shift_q;
    dp_d      = dp_q;
    dm_d      = dm_q;
    tx_done_d = 1'b0;
    t_read_c  = 1'b0;
    adv       = 1'b0;
    snd       = 1'b0;
    nb        = 1'b1;
    // ones count including the bit currently on the line
    ones_nx   = shift_q[0] ? ones_q + 3'd1 : 3'd0;

    case (state_q)
      IDLE: begin
        timer_d = 3'd0;
        dp_d    = 1'b1;
        dm_d    = 1'b0;
        // a start coinciding with tx_done is dropped on purpose
        if (bus.tx_start && !bus.t_empty && !tx_done_q) begin
          state_d   = SYNC;
          bit_cnt_d = 3'd0;
          shift_d   = 8'h80;
          ones_d    = 3'd0;
          snd       = 1'b1;
          nb        = 1'b0;
        end
      end
      SYNC, DATA: begin
        if (timer_q == 3'd7) begin
          if (ones_nx == 3'd6) begin
            state_d = STUFF;
            ones_d  = 3'd0;
            snd     = 1'b1;
            nb      = 1'b0;
          end else begin
            ones_d = ones_nx;
            adv    = 1'b1;
          end
        end
      end
      STUFF: begin
        if (timer_q == 3'd7) adv = 1'b1;
      end
      EOP_SE0: begin
        if (timer_q == 3'd7) begin
          if (bit_cnt_q == 3'd0) begin
            bit_cnt_d = 3'd1;
          end else begin
            state_d = EOP_J;
            dp_d    = 1'b1;
            dm_d    = 1'b0;
          end
        end
      end
      EOP_J: begin
        if (timer_q == 3'd7) begin
          state_d   = IDLE;
          tx_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Move to the next bit; at a byte boundary pop the FIFO or finish.
    if (adv) begin
      if (bit_cnt_q == 3'd7) begin
        if (!bus.t_empty) begin
          t_read_c  = 1'b1;
          shift_d   = bus.t_data;
          bit_cnt_d = 3'd0;
          state_d   = DATA;
          snd       = 1'b1;
          nb        = bus.t_data[0];
        end else begin
          state_d   = EOP_SE0;
          bit_cnt_d = 3'd0;
          dp_d      = 1'b0;
          dm_d      = 1'b0;
        end
      end else begin
        shift_d   = {1'b0, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        state_d   = (state_q == STUFF) ? DATA : state_q;
        snd       = 1'b1;
        nb        = shift_q[1];
      end
    end

    // NRZI: a 0 toggles J/K, a 1 holds the line
    if (snd && !nb) begin
      dp_d = ~dp_q;
      dm_d = dp_q;
    end
  end

  assign bus.t_read       = t_read_c && !n_rst;
  assign bus.d_plus       = dp_q;
  assign bus.d_minus      = dm_q;
  assign bus.transmitting = (state_q != IDLE);
  assign bus.tx_done      = tx_done_q;

endmodule

// File: tb/tb_usb_transmitter.sv
// Self-checking bench for usb_transmitter: packet table with an NRZI decoder
// feeding a byte scoreboard, plus directed reset/ignore sequences.
module tb_usb_transmitter;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  usb_transmitter_if bus();

  usb_transmitter dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [23:0] data;
    int nbytes;
    int pop0;
    int pop1;
    int pop2;
    int done_cyc;
    int nstuff;
    int stuff_pos;
  } vec_t;

  vec_t vecs[4];
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic set_head();
    if (fifo_q.size() > 0) begin
      bus.t_empty = 1'b0;
      bus.t_data  = fifo_q[0];
    end else begin
      bus.t_empty = 1'b1;
      bus.t_data  = 8'h00;
    end
  endtask

  task automatic run_packet(input vec_t v, input bit poke);
    int pops[$];
    int ep[3];
    int done_c;
    int ones, nbits, se0_n, j_n, stuffs, spos, tx_bad, bad;
    bit se0_seen, prev_dp, b, popped;
    logic [7:0] shreg;
    ep[0] = v.pop0; ep[1] = v.pop1; ep[2] = v.pop2;
    done_c = -1; ones = 0; nbits = 0; se0_n = 0; j_n = 0;
    stuffs = 0; spos = -1; tx_bad = 0; se0_seen = 0; prev_dp = 1'b1; shreg = 8'h00;
    for (int i = 0; i < v.nbytes; i++) begin
      fifo_q.push_back(v.data[8*i +: 8]);
      exp_q.push_back(v.data[8*i +: 8]);
    end
    set_head();
    @(negedge clk);
    bus.tx_start = 1'b1;
    @(posedge clk);
    #1 bus.tx_start = 1'b0;
    for (int c = 0; c < 400 && done_c < 0; c++) begin
      @(negedge clk);
      if (bus.tx_done) begin
        done_c = c;
        chk("transmitting_at_done", int'(bus.transmitting), 0);
      end else if (!bus.transmitting) begin
        tx_bad++;
      end
      if (bus.t_read) pops.push_back(c);
      if (!bus.d_plus && !bus.d_minus) begin
        se0_n++;
        se0_seen = 1'b1;
      end else if (se0_seen && bus.transmitting) begin
        j_n++;
      end
      if (!se0_seen && (c % 8) == 4) begin
        b = (bus.d_plus == prev_dp);
        prev_dp = bus.d_plus;
        if (ones == 6) begin
          stuffs++;
          if (spos < 0) spos = nbits;
          chk("stuff_bit_zero", int'(b), 0);
          ones = 0;
        end else begin
          ones  = b ? ones + 1 : 0;
          shreg = {b, shreg[7:1]};
          nbits++;
          if (nbits == 8) chk("sync", int'(shreg), 8'h80);
          else if (nbits > 8 && (nbits % 8) == 0) begin
            if (exp_q.size() == 0) chk("sb_extra_byte", 1, 0);
            else chk("byte", int'(shreg), int'(exp_q.pop_front()));
          end
        end
      end
      if (done_c >= 0 && poke) begin
        bus.t_empty  = 1'b0;
        bus.t_data   = 8'hAA;
        bus.tx_start = 1'b1;
      end
      popped = bus.t_read;
      @(posedge clk);
      #1;
      if (popped) begin
        void'(fifo_q.pop_front());
        set_head();
      end
      bus.tx_start = (c == 100);
    end
    chk("done_cycle", done_c, v.done_cyc);
    chk("pop_count", pops.size(), v.nbytes);
    for (int i = 0; i < v.nbytes && i < pops.size(); i++) chk("pop_cycle", pops[i], ep[i]);
    chk("se0_cycles", se0_n, 16);
    chk("eop_j_cycles", j_n, 8);
    chk("transmitting_gaps", tx_bad, 0);
    chk("stuff_count", stuffs, v.nstuff);
    chk("stuff_pos", spos, v.stuff_pos);
    chk("sb_leftover", exp_q.size(), 0);
    chk("trailing_bits", nbits % 8, 0);
    if (poke) begin
      bad = 0;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        if (bus.transmitting || bus.t_read || !bus.d_plus || bus.d_minus) bad++;
      end
      chk("start_at_done_ignored", bad, 0);
      bus.t_empty = 1'b1;
    end
    exp_q.delete();
    fifo_q.delete();
    set_head();
  endtask

  initial begin
    int bad;
    int dones;
    bit popped;
    vecs[0] = '{24'h000055, 1, 63, -1, -1, 152, 0, -1};
    vecs[1] = '{24'h614000, 3, 63, 127, 191, 280, 0, -1};
    vecs[2] = '{24'h0000FF, 1, 63, -1, -1, 160, 1, 13};
    vecs[3] = '{24'h0000FC, 1, 63, -1, -1, 160, 1, 16};

    bus.tx_start = 1'b0;
    bus.t_empty  = 1'b1;
    bus.t_data   = 8'h00;
    n_rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_d_plus", int'(bus.d_plus), 1);
    chk("rst_d_minus", int'(bus.d_minus), 0);
    chk("rst_transmitting", int'(bus.transmitting), 0);
    chk("rst_t_read", int'(bus.t_read), 0);
    chk("rst_tx_done", int'(bus.tx_done), 0);
    n_rst = 1'b0;

    // start with an empty FIFO must be ignored
    bus.t_empty = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b1;
    @(posedge clk);
    #1 bus.tx_start = 1'b0;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!bus.d_plus || bus.d_minus || bus.transmitting || bus.t_read) bad++;
    end
    chk("empty_start_ignored", bad, 0);

    for (int i = 0; i < 4; i++) run_packet(vecs[i], i == 3);

    // reset in the middle of the first data byte of a 3-byte packet
    fifo_q.push_back(8'h12);
    fifo_q.push_back(8'h34);
    fifo_q.push_back(8'h56);
    set_head();
    @(negedge clk);
    bus.tx_start = 1'b1;
    @(posedge clk);
    #1 bus.tx_start = 1'b0;
    for (int c = 0; c < 90; c++) begin
      @(negedge clk);
      popped = bus.t_read;
      @(posedge clk);
      #1;
      if (popped) begin
        void'(fifo_q.pop_front());
        set_head();
      end
    end
    chk("pre_abort_transmitting", int'(bus.transmitting), 1);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_d_plus", int'(bus.d_plus), 1);
    chk("abort_d_minus", int'(bus.d_minus), 0);
    chk("abort_transmitting", int'(bus.transmitting), 0);
    @(negedge clk);
    n_rst = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    set_head();
    dones = 0;
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.tx_done) dones++;
      if (bus.transmitting || !bus.d_plus || bus.d_minus) bad++;
    end
    chk("abort_no_tx_done", dones, 0);
    chk("abort_idle_lines", bad, 0);
    run_packet(vecs[0], 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_transmitter.md
USB_TRANSMITTER -- requirements
Module: usb_transmitter

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Ports SHALL be as follows, clock and reset first:
- clk  in  1  system clock; one USB bit = 8 clk cycles
- n_rst  in  1  synchronous, active-high reset; the name follows the codebase, the polarity is as stated
- tx_start  in  1  one-cycle request to send a packet
- t_data  in  8  FIFO head byte, first-word-fall-through, valid while t_empty=0
- t_empty  in  1  FIFO has no bytes
- t_read  out  1  one-cycle pop of the FIFO head byte
- d_plus  out  1  USB D+ line, registered
- d_minus  out  1  USB D- line, registered
- transmitting  out  1  high from the first SYNC bit through the final J bit
- tx_done  out  1  one-cycle pulse when the packet ends

Function
REQ-003 The line state SHALL be idle J (d_plus=1, d_minus=0) whenever the block is not transmitting.
REQ-004 The FSM SHALL have the states IDLE, SYNC, DATA, STUFF, EOP_SE0 and EOP_J.
REQ-005 In IDLE, tx_start=1 with t_empty=0 SHALL move the FSM to SYNC.
REQ-006 In IDLE, tx_start with t_empty=1 SHALL be ignored; tx_start outside IDLE SHALL also be ignored.
REQ-007 The first SYNC bit SHALL appear on the lines in the cycle after tx_start is sampled.
REQ-008 Every bit, including stuffed bits, SHALL be held exactly 8 cycles, with a 3-bit timer (0-7) advancing on each bit.
REQ-009 Bits SHALL be NRZI encoded:
- logical 0: toggle J/K; d_minus = ~d_plus during data
- logical 1: hold the current line state
REQ-010 SYNC SHALL be 8'b10000000, sent LSB first (seven 0s, then a 1).
REQ-011 Data bytes SHALL be sent LSB first.
REQ-012 t_read SHALL assert for exactly one cycle, in the last cycle (timer=7) of the final bit of SYNC or of the current byte, and only when t_empty=0.
REQ-013 The popped t_data SHALL be latched into the shift register on that same edge.
REQ-014 If t_empty=1 at the end of a byte (after any pending stuff bit), the FSM SHALL go to EOP_SE0 and t_read SHALL stay 0.
REQ-015 Consecutive logical 1s SHALL be counted from the start of SYNC.
REQ-016 After the sixth consecutive 1, the FSM SHALL insert one stuffed 0 (STUFF state, toggle) and then clear the counter.
REQ-017 Any transmitted 0 SHALL clear the consecutive-1 counter.
REQ-018 Stuffing SHALL apply after the last data bit before EOP.
REQ-019 Stuffing SHALL delay later bits and the pop timing by one bit period.
REQ-020 EOP_SE0 SHALL drive d_plus=0 and d_minus=0 for 16 cycles.
REQ-021 EOP_J SHALL drive J for 8 cycles, then return to IDLE.
REQ-022 tx_done SHALL pulse for one cycle on the edge that enters IDLE from EOP_J.
REQ-023 transmitting SHALL be 1 in SYNC, DATA, STUFF, EOP_SE0 and EOP_J, and 0 in IDLE.
REQ-024 Packet length SHALL be unbounded; the block sends bytes until the FIFO is empty at a byte boundary.
REQ-025 tx_start arriving in the cycle tx_done pulses SHALL be ignored; a new packet requires tx_start in IDLE.
REQ-026 There SHALL be no combinational path from any input to d_plus or d_minus.

Reset
REQ-027 On n_rst=1 at a clock edge, the block SHALL force:
- state IDLE, timer 0, ones-counter 0, shift register 0x00
- d_plus=1, d_minus=0
- t_read=0, transmitting=0, tx_done=0
REQ-028 n_rst asserted mid-packet SHALL abort the packet, with J on the lines at the next edge and no tx_done pulse.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Reset held 2 cycles -> d_plus=1, d_minus=0, transmitting=0, t_read=0, tx_done=0.
- FIFO={0x55}, tx_start pulse -> t_read once, at cycle 63 after start; lines decode to SYNC then 0x55 LSB first; SE0 for 16 cycles, J for 8; tx_done at cycle 152 (19 bit times).
- FIFO={0x00,0x40,0x61} -> t_read pulses 64 cycles apart; decoded bytes 0x00, 0x40, 0x61 in order; tx_done at cycle 280.
- FIFO={0xFF} -> stuffed 0 after the 5th data bit (the SYNC final 1 plus 5 data 1s makes six); byte spans 9 bit times; tx_done at cycle 160.
- tx_start while t_empty=1 -> lines stay J, transmitting=0, t_read never asserts.
- n_rst pulsed mid-byte of a 3-byte packet -> J and transmitting=0 at the next edge, no tx_done; a later tx_start sends a full packet normally.
